// File: rtl/stream_template_classifier.sv
// stream_template_classifier: scores each streamed binary image against ternary templates and emits the winning class (optional res_score output via TMPL_SCORE_OUT_EN)
module stream_template_classifier #(
   parameter int IMG_W         = 7,
   parameter int IMG_H         = 7,
   parameter int N_TMPL        = 8,
   parameter int CLASS_W       = 4,
   parameter int DEFAULT_CLASS = 1,
   localparam int SW           = $clog2(IMG_W*IMG_H+1)+1,
   localparam int IW           = $clog2(N_TMPL),
   localparam int RW           = $clog2(IMG_H)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [IMG_W-1:0]   pix_row,
   input  logic               tmpl_we,
   input  logic [IW-1:0]      tmpl_idx,
   input  logic [RW-1:0]      tmpl_rsel,
   input  logic [IMG_W-1:0]   tmpl_pos,
   input  logic [IMG_W-1:0]   tmpl_neg,
   input  logic               thr_we,
   input  logic [SW-1:0]      thr_val,
   input  logic [CLASS_W-1:0] thr_cls,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CLASS_W-1:0] res_class,
   output logic               res_hit
`ifdef TMPL_SCORE_OUT_EN
   ,
   output logic [SW-1:0]      res_score
`endif
);

   typedef enum logic [1:0] {LOAD, EVAL, HOLD} state_e;

   state_e                    state_q, state_d;
   logic [RW-1:0]             row_cnt_q, row_cnt_d;
   logic [IMG_W-1:0]          pos_q [N_TMPL][IMG_H];
   logic [IMG_W-1:0]          neg_q [N_TMPL][IMG_H];
   logic signed [SW-1:0]      thr_q [N_TMPL];
   logic [CLASS_W-1:0]        cls_q [N_TMPL];
   logic signed [SW-1:0]      score_q [N_TMPL];
   logic signed [SW-1:0]      score_d [N_TMPL];
   logic [CLASS_W-1:0]        res_class_q, win_cls;
   logic                      res_hit_q, any_hit;
   logic                      accept, cfg_ok, tmpl_ok, thr_ok;
`ifdef TMPL_SCORE_OUT_EN
   logic signed [SW-1:0]      res_score_q, win_score, max_score;
`endif

   function automatic logic signed [SW-1:0] popcnt(input logic [IMG_W-1:0] v);
      logic signed [SW-1:0] n;
      n = '0;
      for (int i = 0; i < IMG_W; i++) n = n + SW'(v[i]);
      return n;
   endfunction

   assign accept  = pix_valid && pix_ready;
   assign cfg_ok  = (state_q == LOAD) && (row_cnt_q == '0) && !accept;
   assign tmpl_ok = cfg_ok && tmpl_we && ({1'b0, tmpl_idx} < (IW+1)'(N_TMPL)) && ({1'b0, tmpl_rsel} < (RW+1)'(IMG_H));
   assign thr_ok  = cfg_ok && thr_we && ({1'b0, tmpl_idx} < (IW+1)'(N_TMPL));

   // FSM next state, row counter and handshake outputs
   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      pix_ready = (state_q == LOAD);
      res_valid = (state_q == HOLD);
      if (accept) begin
         row_cnt_d = (row_cnt_q == RW'(IMG_H-1)) ? '0 : row_cnt_q + 1'b1;
         state_d   = (row_cnt_q == RW'(IMG_H-1)) ? EVAL : LOAD;
      end
      if (state_q == EVAL) state_d = HOLD;
      if (state_q == HOLD && res_ready) state_d = LOAD;
   end

   // per-template score accumulation; a pixel in both masks cancels to zero
   always_comb begin
      for (int t = 0; t < N_TMPL; t++)
         score_d[t] = (state_q == EVAL) ? '0 :
                      accept ? score_q[t] + popcnt(pix_row & pos_q[t][row_cnt_q]) - popcnt(pix_row & neg_q[t][row_cnt_q]) :
                      score_q[t];
   end

   // threshold compare and lowest-index priority pick (scanned high to low so lowest wins)
   always_comb begin
      win_cls = CLASS_W'(DEFAULT_CLASS);
      any_hit = 1'b0;
`ifdef TMPL_SCORE_OUT_EN
      win_score = '0;
      max_score = score_q[0];
`endif
      for (int t = N_TMPL-1; t >= 0; t--) begin
         if (score_q[t] >= thr_q[t]) begin
            win_cls = cls_q[t];
            any_hit = 1'b1;
`ifdef TMPL_SCORE_OUT_EN
            win_score = score_q[t];
`endif
         end
`ifdef TMPL_SCORE_OUT_EN
         if (score_q[t] > max_score) max_score = score_q[t];
`endif
      end
   end

   // state, scores, template store and registered result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LOAD;
         row_cnt_q   <= '0;
         res_class_q <= '0;
         res_hit_q   <= 1'b0;
`ifdef TMPL_SCORE_OUT_EN
         res_score_q <= '0;
`endif
         for (int t = 0; t < N_TMPL; t++) begin
            score_q[t] <= '0;
            thr_q[t]   <= {1'b0, {(SW-1){1'b1}}};
            cls_q[t]   <= '0;
            for (int r = 0; r < IMG_H; r++) begin
               pos_q[t][r] <= '0;
               neg_q[t][r] <= '0;
            end
         end
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         for (int t = 0; t < N_TMPL; t++) score_q[t] <= score_d[t];
         if (tmpl_ok) begin
            pos_q[tmpl_idx][tmpl_rsel] <= tmpl_pos;
            neg_q[tmpl_idx][tmpl_rsel] <= tmpl_neg;
         end
         if (thr_ok) begin
            thr_q[tmpl_idx] <= thr_val;
            cls_q[tmpl_idx] <= thr_cls;
         end
         if (state_q == EVAL) begin
            res_class_q <= win_cls;
            res_hit_q   <= any_hit;
`ifdef TMPL_SCORE_OUT_EN
            res_score_q <= any_hit ? win_score : max_score;
`endif
         end
      end
   end

   assign res_class = res_class_q;
   assign res_hit   = res_hit_q;
`ifdef TMPL_SCORE_OUT_EN
   assign res_score = res_score_q;
`endif

endmodule
